// File: rtl/fifo_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_sched
// Purpose  : Avalon-MM controlled scheduler that watches a FIFO fill level
//            and sequences drain bursts to a consumer via req/ack/done.
//            Optional BUSY watchdog enabled by FIFO_DRAIN_TIMEOUT_EN.
//            USEDW_W must not exceed the 32-bit register width.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_sched #(
  parameter int USEDW_W     = 32,
  parameter int FIFO_DEPTH  = 1024,
  parameter int HOLDOFF_CYC = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [USEDW_W-1:0] usedw,
  output logic               drain_req,
  output logic [USEDW_W-1:0] drain_len,
  input  logic               drain_ack,
  input  logic               drain_done,
  output logic               irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int                  c_HOLD_W    = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLDOFF_CYC - 1);
  localparam logic [USEDW_W-1:0]  c_DEPTH     = USEDW_W'(FIFO_DEPTH);
  localparam logic [USEDW_W-1:0]  c_BURST_RST = USEDW_W'(16);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_enable;
  logic                 r_irq_done_en;
  logic                 r_irq_ovf_en;
  logic [USEDW_W-1:0]   r_thresh;
  logic [USEDW_W-1:0]   r_burst;
  logic                 r_done_evt;
  logic                 r_ovf_evt;
  logic                 r_timeout_evt;
  logic [31:0]          r_count;
  logic [USEDW_W-1:0]   r_len;
  logic [c_HOLD_W-1:0]  r_hold_cnt;
  logic [31:0]          r_readdata;
  logic                 r_irq;

  logic                 w_wr;
  logic                 w_w1c;
  logic                 w_trigger;
  logic                 w_load_len;
  logic                 w_burst_done;
  logic                 w_timeout_hit;
  logic [USEDW_W-1:0]   w_len_sel;
  logic [31:0]          w_rd_mux;

  assign w_wr      = chipselect & ~write_n;
  assign w_w1c     = w_wr && (address == 3'd3);
  assign w_trigger = r_enable && (r_thresh != '0) && (usedw >= r_thresh);
  // A zero burst limit means "drain everything currently in the FIFO".
  assign w_len_sel = ((r_burst == '0) || (usedw < r_burst)) ? usedw : r_burst;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  logic [31:0] r_wdog;

  // Watchdog counts BUSY cycles; held at zero outside BUSY so it restarts on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_wdog <= '0;
    else if (r_state != ST_BUSY) r_wdog <= '0;
    else                         r_wdog <= r_wdog + 32'd1;
  end

  // A done arriving on the final watchdog cycle still counts as a completion
  assign w_timeout_hit = (r_state == ST_BUSY) && !drain_done &&
                         (r_wdog == 32'(TIMEOUT_CYC - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode plus the one-cycle control strobes that go with it
  always_comb begin
    w_state_next = r_state;
    w_load_len   = 1'b0;
    w_burst_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_state_next = ST_REQ;
          w_load_len   = 1'b1;
        end
      end
      ST_REQ: begin
        if (drain_ack)      w_state_next = ST_BUSY;
        else if (!r_enable) w_state_next = ST_IDLE;
      end
      ST_BUSY: begin
        if (drain_done) begin
          w_state_next = ST_HOLD;
          w_burst_done = 1'b1;
        end else if (w_timeout_hit) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Holdoff counter: loaded on HOLD entry, counts down to zero while in HOLD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_hold_cnt <= '0;
    else if ((w_state_next == ST_HOLD) && (r_state != ST_HOLD))
      r_hold_cnt <= c_HOLD_LOAD;
    else if ((r_state == ST_HOLD) && (r_hold_cnt != '0))
      r_hold_cnt <= r_hold_cnt - 1'b1;
  end

  // Burst length latched only at the trigger so later register writes cannot disturb it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_len <= '0;
    else if (w_load_len) r_len <= w_len_sel;
  end

  // Software-programmable control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable      <= 1'b0;
      r_irq_done_en <= 1'b0;
      r_irq_ovf_en  <= 1'b0;
      r_thresh      <= '0;
      r_burst       <= c_BURST_RST;
    end else if (w_wr) begin
      case (address)
        3'd0: begin
          r_enable      <= writedata[0];
          r_irq_done_en <= writedata[1];
          r_irq_ovf_en  <= writedata[2];
        end
        3'd1:    r_thresh <= writedata[USEDW_W-1:0];
        3'd2:    r_burst  <= writedata[USEDW_W-1:0];
        default: ;
      endcase
    end
  end

  // Sticky events: a new event in the same cycle beats the write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_evt    <= 1'b0;
      r_ovf_evt     <= 1'b0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_done_evt    <= w_burst_done | (r_done_evt & ~(w_w1c & writedata[0]));
      r_ovf_evt     <= (usedw >= c_DEPTH) | (r_ovf_evt & ~(w_w1c & writedata[1]));
      r_timeout_evt <= w_timeout_hit | (r_timeout_evt & ~(w_w1c & writedata[2]));
    end
  end

  // Completed-burst counter; any write to it clears, a coincident completion counts as one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (w_wr && (address == 3'd4))
      r_count <= w_burst_done ? 32'd1 : 32'd0;
    else if (w_burst_done)
      r_count <= r_count + 32'd1;
  end

  // Read-data mux, registered below for a fixed one-cycle read latency
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      3'd0:    w_rd_mux = {29'd0, r_irq_ovf_en, r_irq_done_en, r_enable};
      3'd1:    w_rd_mux = 32'(r_thresh);
      3'd2:    w_rd_mux = 32'(r_burst);
      3'd3:    w_rd_mux = {21'd0, 1'b0, r_state, 5'd0, r_timeout_evt, r_ovf_evt, r_done_evt};
      3'd4:    w_rd_mux = r_count;
      3'd5:    w_rd_mux = 32'(usedw);
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Registered read data and interrupt (irq lags its event bit by one cycle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rd_mux;
      r_irq      <= (r_done_evt & r_irq_done_en) | (r_ovf_evt & r_irq_ovf_en) |
                    (r_timeout_evt & r_irq_done_en);
    end
  end

  assign readdata  = r_readdata;
  assign irq       = r_irq;
  assign drain_req = (r_state == ST_REQ);
  assign drain_len = r_len;

endmodule
`default_nettype wire
